// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_if
// Description : Requester-side bundle for sram_port_arbiter. It carries the
//               read channel, the byte-masked write channel and the clear
//               request and status signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
  parameter int P_DW = 6,
  parameter int AW   = 6
);
  localparam int C_DW = 1 << P_DW;
  localparam int C_BW = C_DW / 8;

  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   rd_addr;
  logic            rd_rvalid;
  logic [C_DW-1:0] rd_rdata;

  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [C_BW-1:0] wr_be;
  logic [C_DW-1:0] wr_data;

  logic            init_req;
  logic            init_busy;

  // Requester side: drives requests and observes grants and responses.
  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_be, wr_data, init_req,
    input  rd_ready, rd_rvalid, rd_rdata, wr_ready, init_busy
  );

  // Arbiter side.
  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_be, wr_data, init_req,
    output rd_ready, rd_rvalid, rd_rdata, wr_ready, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port byte-enable SRAM between a read and a
//               write requester with round-robin arbitration. It zero-fills
//               the array after reset or on request. Read data is held stable
//               between response pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int P_DW    = 6,
  parameter int AW      = 6,
  parameter int INIT_EN = 1
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_n_i,
  sram_port_arbiter_if.slave             bus,
  output logic [AW-1:0]                  ram_addr_o,
  output logic                           ram_re_o,
  output logic [((1 << P_DW) / 8)-1:0]   ram_we_o,
  output logic [(1 << P_DW)-1:0]         ram_din_o,
  input  wire logic [(1 << P_DW)-1:0]    ram_dout_i
);

  localparam int C_DW = 1 << P_DW;
  localparam int C_BW = C_DW / 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam state_e C_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_SERVE;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  // Set when the most recent grant went to the read side; the other side is
  // then favoured on a tie.
  logic            last_rd_q, last_rd_d;
  logic            rvalid_q;
  logic [C_DW-1:0] hold_q;

  logic            w_rd_gnt;
  logic            w_wr_gnt;

  // State, clear counter, round-robin pointer and read-response registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= C_RST_STATE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      rvalid_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      rvalid_q  <= w_rd_gnt;
      if (rvalid_q) begin
        hold_q <= ram_dout_i;
      end
    end
  end

  // Next state, arbitration and RAM port drive.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_rd_d  = last_rd_q;
    w_rd_gnt   = 1'b0;
    w_wr_gnt   = 1'b0;
    ram_addr_o = bus.rd_addr;
    ram_din_o  = bus.wr_data;
    ram_re_o   = 1'b0;
    ram_we_o   = '0;

    case (state_q)
      ST_INIT: begin
        ram_addr_o = cnt_q;
        ram_we_o   = '1;
        ram_din_o  = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (bus.init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          w_rd_gnt = bus.rd_valid && (!bus.wr_valid || !last_rd_q);
          w_wr_gnt = bus.wr_valid && (!bus.rd_valid ||  last_rd_q);
        end
      end
      default: begin
        state_d = C_RST_STATE;
      end
    endcase

    // The RAM must see no access while reset is held, whatever the state.
    if (!rst_n_i) begin
      w_rd_gnt = 1'b0;
      w_wr_gnt = 1'b0;
      ram_we_o = '0;
    end

    if (w_rd_gnt) begin
      ram_addr_o = bus.rd_addr;
      ram_re_o   = 1'b1;
      last_rd_d  = 1'b1;
    end else if (w_wr_gnt) begin
      ram_addr_o = bus.wr_addr;
      ram_we_o   = bus.wr_be;
      ram_din_o  = bus.wr_data;
      last_rd_d  = 1'b0;
    end
  end

  assign bus.rd_ready  = w_rd_gnt;
  assign bus.wr_ready  = w_wr_gnt;
  assign bus.init_busy = (state_q == ST_INIT);
  assign bus.rd_rvalid = rvalid_q;
  // Pass RAM output through only in the response cycle; otherwise present the
  // captured copy so later writes never expose undefined RAM output.
  assign bus.rd_rdata  = rvalid_q ? ram_dout_i : hold_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter with a behavioural
//               SRAM and a reference model of memory contents and grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [5:0]  ram_addr;
  logic        ram_re;
  logic [7:0]  ram_we;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;
  logic        scramble;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter_if #(.P_DW(6), .AW(6)) bus ();

  sram_port_arbiter #(.P_DW(6), .AW(6), .INIT_EN(1)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .ram_addr_o (ram_addr),
    .ram_re_o   (ram_re),
    .ram_we_o   (ram_we),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 1-cycle read latency and garbage output on any cycle
  // without a read.
  logic [63:0] ram_mem [64];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= {$urandom, $urandom};
    end else begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    ram_dout <= ram_re ? ram_mem[ram_addr] : {$urandom, $urandom};
  end

  // Reference model state.
  logic [63:0] mem_m [64];
  logic        m_busy;
  int          m_idx;
  logic        m_pend_v;
  logic [63:0] m_pend_d;
  logic [63:0] m_held;
  logic        m_last_rd;

  logic        cur_rv, cur_wv, cur_ir;
  logic [5:0]  cur_ra, cur_wa;
  logic [7:0]  cur_be;
  logic [63:0] cur_wd;

  logic        exp_rr, exp_wr, exp_rvalid;
  logic [63:0] exp_rdata;
  logic [7:0]  exp_we;

  task automatic model_reset();
    m_busy = 1'b1; m_idx = 0; m_pend_v = 1'b0; m_pend_d = '0;
    m_held = '0; m_last_rd = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
  endtask

  task automatic drive(input logic rv, input logic [5:0] ra, input logic wv,
                       input logic [5:0] wa, input logic [7:0] be,
                       input logic [63:0] wd, input logic ir);
    bus.rd_valid = rv; bus.rd_addr = ra; bus.wr_valid = wv; bus.wr_addr = wa;
    bus.wr_be = be; bus.wr_data = wd; bus.init_req = ir;
    cur_rv = rv; cur_ra = ra; cur_wv = wv; cur_wa = wa; cur_be = be;
    cur_wd = wd; cur_ir = ir;
    exp_rr     = rst_n && !m_busy && !ir && rv && (!wv || !m_last_rd);
    exp_wr     = rst_n && !m_busy && !ir && wv && (!rv ||  m_last_rd);
    exp_rvalid = m_pend_v;
    exp_rdata  = m_pend_v ? m_pend_d : m_held;
    exp_we     = m_busy ? 8'hFF : (exp_wr ? be : 8'h00);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pend_v) m_held = m_pend_d;
      m_pend_v = exp_rr;
      if (exp_rr) m_pend_d = mem_m[cur_ra];
      if (exp_wr)
        for (int b = 0; b < 8; b++)
          if (cur_be[b]) mem_m[cur_wa][b*8 +: 8] = cur_wd[b*8 +: 8];
      if (exp_rr) m_last_rd = 1'b1;
      else if (exp_wr) m_last_rd = 1'b0;
      if (m_busy) begin
        m_idx++;
        if (m_idx == 64) begin m_busy = 1'b0; m_idx = 0; end
      end else if (cur_ir) begin
        m_busy = 1'b1; m_idx = 0;
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h2A, 1'b1, 6'h01, 8'hFF, 64'hFFFF, 1'b0);
      total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL rst_ram_re got=%b exp=0", ram_re); end
      total++; if (ram_we !== 8'h00) begin bad++; $display("FAIL rst_ram_we got=%h exp=00", ram_we); end
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'h2A, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
      total++; if (bus.init_busy !== 1'b1) begin bad++; $display("FAIL init_busy i=%0d got=%b exp=1", i, bus.init_busy); end
      total++; if (ram_we !== 8'hFF) begin bad++; $display("FAIL init_we i=%0d got=%h exp=ff", i, ram_we); end
      total++; if (ram_addr !== 6'(i)) begin bad++; $display("FAIL init_addr got=%0d exp=%0d", ram_addr, i); end
      total++; if (ram_din !== 64'd0) begin bad++; $display("FAIL init_din got=%h exp=0", ram_din); end
      total++; if (bus.rd_ready !== 1'b0) begin bad++; $display("FAIL init_rd_ready i=%0d got=%b exp=0", i, bus.rd_ready); end
      if (i == 0) begin
        total++; if (bus.rd_rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.rd_rdata); end
      end
      tick();
    end
    drive(1'b1, 6'h2A, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
    total++; if (bus.init_busy !== 1'b0) begin bad++; $display("FAIL post_init_busy got=%b exp=0", bus.init_busy); end
    total++; if (bus.rd_ready !== 1'b1 || ram_re !== 1'b1 || ram_addr !== 6'h2A) begin
      bad++; $display("FAIL first_read got=%b/%b/%h exp=1/1/2a", bus.rd_ready, ram_re, ram_addr); end
    tick();
    idle();
    total++; if (bus.rd_rvalid !== 1'b1 || bus.rd_rdata !== 64'd0) begin
      bad++; $display("FAIL cleared_read got=%b/%h exp=1/0", bus.rd_rvalid, bus.rd_rdata); end
    tick();
  endtask

  task automatic test_byte_write();
    drive(1'b0, 6'd0, 1'b1, 6'd5, 8'hFF, 64'h1122334455667788, 1'b0);
    total++; if (bus.wr_ready !== 1'b1 || ram_we !== 8'hFF || ram_addr !== 6'd5) begin
      bad++; $display("FAIL bw_full got=%b/%h/%h exp=1/ff/05", bus.wr_ready, ram_we, ram_addr); end
    tick();
    drive(1'b0, 6'd0, 1'b1, 6'd5, 8'h01, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    total++; if (ram_we !== 8'h01 || ram_re !== 1'b0) begin
      bad++; $display("FAIL bw_byte got=%h/%b exp=01/0", ram_we, ram_re); end
    tick();
    drive(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
    total++; if (bus.rd_ready !== 1'b1 || bus.rd_rvalid !== 1'b0) begin
      bad++; $display("FAIL bw_rd_grant got=%b/%b exp=1/0", bus.rd_ready, bus.rd_rvalid); end
    tick();
    idle();
    total++; if (bus.rd_rvalid !== 1'b1 || bus.rd_rdata !== 64'h11223344556677AA) begin
      bad++; $display("FAIL bw_data got=%b/%h exp=1/11223344556677aa", bus.rd_rvalid, bus.rd_rdata); end
    tick();
    for (int i = 0; i < 10; i++) begin
      idle();
      total++; if (bus.rd_rvalid !== 1'b0 || bus.rd_rdata !== 64'h11223344556677AA) begin
        bad++; $display("FAIL bw_hold i=%0d got=%b/%h exp=0/11223344556677aa", i, bus.rd_rvalid, bus.rd_rdata); end
      tick();
    end
  endtask

  task automatic test_alternate();
    logic prev_rr;
    prev_rr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'($urandom_range(0, 63)), 1'b1, 6'($urandom_range(0, 63)),
            8'($urandom), {$urandom, $urandom}, 1'b0);
      total++; if (bus.rd_ready !== exp_rr || bus.wr_ready !== exp_wr) begin
        bad++; $display("FAIL alt_grant i=%0d got=%b%b exp=%b%b", i, bus.rd_ready, bus.wr_ready, exp_rr, exp_wr); end
      total++; if ((bus.rd_ready ^ bus.wr_ready) !== 1'b1) begin
        bad++; $display("FAIL alt_onehot i=%0d got=%b%b exp=one grant", i, bus.rd_ready, bus.wr_ready); end
      if (i > 0) begin
        total++; if (bus.rd_ready === prev_rr) begin
          bad++; $display("FAIL alt_toggle i=%0d got=%b exp=%b", i, bus.rd_ready, !prev_rr); end
      end
      total++; if (bus.rd_rvalid !== exp_rvalid || bus.rd_rdata !== exp_rdata) begin
        bad++; $display("FAIL alt_resp i=%0d got=%b/%h exp=%b/%h", i, bus.rd_rvalid, bus.rd_rdata, exp_rvalid, exp_rdata); end
      prev_rr = bus.rd_ready;
      tick();
    end
    idle();
    total++; if (bus.rd_rvalid !== exp_rvalid || bus.rd_rdata !== exp_rdata) begin
      bad++; $display("FAIL alt_drain got=%b/%h exp=%b/%h", bus.rd_rvalid, bus.rd_rdata, exp_rvalid, exp_rdata); end
    tick();
  endtask

  task automatic test_raw();
    drive(1'b0, 6'd0, 1'b1, 6'd9, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
    tick();
    drive(1'b1, 6'd9, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
    total++; if (bus.rd_ready !== 1'b1) begin bad++; $display("FAIL raw_rd1 got=%b exp=1", bus.rd_ready); end
    tick();
    drive(1'b0, 6'd0, 1'b1, 6'd9, 8'hFF, 64'hFEDCBA9876543210, 1'b0);
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL raw_wr got=%b exp=1", bus.wr_ready); end
    total++; if (bus.rd_rvalid !== 1'b1 || bus.rd_rdata !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL raw_old got=%b/%h exp=1/0123456789abcdef", bus.rd_rvalid, bus.rd_rdata); end
    tick();
    drive(1'b1, 6'd9, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
    total++; if (bus.rd_rdata !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL raw_hold got=%h exp=0123456789abcdef", bus.rd_rdata); end
    tick();
    idle();
    total++; if (bus.rd_rvalid !== 1'b1 || bus.rd_rdata !== 64'hFEDCBA9876543210) begin
      bad++; $display("FAIL raw_new got=%b/%h exp=1/fedcba9876543210", bus.rd_rvalid, bus.rd_rdata); end
    tick();
  endtask

  task automatic test_init_req();
    drive(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'd0, 1'b1);
    total++; if (bus.rd_ready !== 1'b0 || ram_re !== 1'b0 || bus.init_busy !== 1'b0) begin
      bad++; $display("FAIL ireq_cycle got=%b/%b/%b exp=0/0/0", bus.rd_ready, ram_re, bus.init_busy); end
    tick();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
      total++; if (bus.init_busy !== 1'b1 || bus.rd_ready !== 1'b0 || ram_addr !== 6'(i)) begin
        bad++; $display("FAIL ireq_busy i=%0d got=%b/%b/%0d exp=1/0/%0d", i, bus.init_busy, bus.rd_ready, ram_addr, i); end
      tick();
    end
    drive(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'd0, 1'b0);
    total++; if (bus.init_busy !== 1'b0 || bus.rd_ready !== 1'b1) begin
      bad++; $display("FAIL ireq_serve got=%b/%b exp=0/1", bus.init_busy, bus.rd_ready); end
    tick();
    idle();
    total++; if (bus.rd_rvalid !== 1'b1 || bus.rd_rdata !== 64'd0) begin
      bad++; $display("FAIL ireq_read got=%b/%h exp=1/0", bus.rd_rvalid, bus.rd_rdata); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), 6'($urandom_range(0, 7)),
            8'($urandom), {$urandom, $urandom}, ($urandom_range(0, 149) == 0));
      total++; if (bus.rd_ready !== exp_rr || bus.wr_ready !== exp_wr) begin
        bad++; $display("FAIL rnd_grant i=%0d got=%b%b exp=%b%b", i, bus.rd_ready, bus.wr_ready, exp_rr, exp_wr); end
      total++; if (bus.rd_rvalid !== exp_rvalid || bus.rd_rdata !== exp_rdata) begin
        bad++; $display("FAIL rnd_resp i=%0d got=%b/%h exp=%b/%h", i, bus.rd_rvalid, bus.rd_rdata, exp_rvalid, exp_rdata); end
      total++; if (bus.init_busy !== m_busy || ram_we !== exp_we || ram_re !== exp_rr) begin
        bad++; $display("FAIL rnd_ram i=%0d got=%b/%h/%b exp=%b/%h/%b", i, bus.init_busy, ram_we, ram_re, m_busy, exp_we, exp_rr); end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    rst_n = 1'b0;
    idle(); tick(); idle(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      idle();
      total++; if (ram_addr !== 6'(i) || bus.init_busy !== 1'b1) begin
        bad++; $display("FAIL mid_pre i=%0d got=%0d/%b exp=%0d/1", i, ram_addr, bus.init_busy, i); end
      tick();
    end
    rst_n = 1'b0;
    idle();
    total++; if (ram_we !== 8'h00) begin bad++; $display("FAIL mid_rst_we got=%h exp=00", ram_we); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      idle();
      total++; if (ram_addr !== 6'(i) || bus.init_busy !== 1'b1 || ram_we !== 8'hFF) begin
        bad++; $display("FAIL mid_restart i=%0d got=%0d/%b/%h exp=%0d/1/ff", i, ram_addr, bus.init_busy, ram_we, i); end
      tick();
    end
    idle();
    total++; if (bus.init_busy !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", bus.init_busy); end
    tick();
  endtask

  initial begin
    scramble = 1'b1;
    rst_n    = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.wr_valid = 1'b0; bus.wr_addr = '0;
    bus.wr_be = '0; bus.wr_data = '0; bus.init_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    scramble = 1'b0;
    test_reset();
    test_byte_write();
    test_alternate();
    test_raw();
    test_init_req();
    test_random();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
